// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA raster timing generator for the Pong display. A clock divider turns
//   clk into a pixel rate; horizontal/vertical counters walk the raster and
//   registered decodes produce hsync, vsync and the active-video flag. All
//   outputs are registered and the sync/video decodes are taken from the
//   next-state counter values, so every output in a given cycle describes
//   the same (hcount, vcount) position.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   hcount[9:0]  out  current pixel column, 0..H_TOTAL-1
//   vcount[9:0]  out  current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   video_on     out  high while (hcount, vcount) is in the visible area
//   pix_tick     out  one-clk strobe on the first clk of each new pixel
//   frame_start  out  one-clk strobe on the first clk of (0,0) after a wrap

module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A one-clk divider still needs a 1-bit counter that simply stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
    $error("vga_sync_gen: CLK_DIV must be >= 1 and H_TOTAL/V_TOTAL <= 1024");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             advance;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_wrap;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             hs_next;
  logic             vs_next;
  logic             vo_next;

  // Next raster position. When no advance is due the counters hold, so the
  // decodes below can be driven from h_next/v_next on every clk.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    advance    = (div_cnt == DIV_LAST);
    h_wrap     = (hcount == H_LAST);
    v_wrap     = (vcount == V_LAST);
    frame_wrap = advance && h_wrap && v_wrap;
    h_next     = hcount;
    v_next     = vcount;
    if (advance) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? '0 : vcount + 10'd1;
      end else begin
        h_next = hcount + 10'd1;
      end
    end
  end

  // Window decodes on the position the counters are about to hold.
  always_comb begin
    hs_next = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
    vs_next = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
    vo_next = (h_next < H_VIS_END) && (v_next < V_VIS_END);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      div_cnt     <= '0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      video_on    <= 1'b1;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= advance ? '0 : div_cnt + 1'b1;
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      video_on    <= vo_next;
      pix_tick    <= advance;
      // Only a wrap out of the last pixel of a frame can reach (0,0) on an
      // advance, so the first frame after reset never raises this.
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Three instances share clk/reset: the default
// 640x480 timing, and two reduced rasters (16x12 total) so that frame-level
// behaviour fits a short run, one with CLK_DIV=2/active-low syncs and one
// with CLK_DIV=1/active-high syncs. A reference model derives every output
// from the number of clks elapsed since reset was last sampled high.

module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_tick;
    logic       frame_start;
  } obs_t;

  typedef struct {
    int   n;
    obs_t exp;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n     = 0;       // clks since reset was last sampled high
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [9:0] d_hc, d_vc, s_hc, s_vc, f_hc, f_vc;
  logic d_hs, d_vs, d_vo, d_pt, d_fs;
  logic s_hs, s_vs, s_vo, s_pt, s_fs;
  logic f_hs, f_vs, f_vo, f_pt, f_fs;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  vga_sync_gen u_dflt (
    .clk(clk), .reset(reset), .hcount(d_hc), .vcount(d_vc), .hsync(d_hs),
    .vsync(d_vs), .video_on(d_vo), .pix_tick(d_pt), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(reset), .hcount(s_hc), .vcount(s_vc), .hsync(s_hs),
    .vsync(s_vs), .video_on(s_vo), .pix_tick(s_pt), .frame_start(s_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) u_fast (
    .clk(clk), .reset(reset), .hcount(f_hc), .vcount(f_vc), .hsync(f_hs),
    .vsync(f_vs), .video_on(f_vo), .pix_tick(f_pt), .frame_start(f_fs)
  );

  obs_t obs_d, obs_s, obs_f;
  assign obs_d = {d_hc, d_vc, d_hs, d_vs, d_vo, d_pt, d_fs};
  assign obs_s = {s_hc, s_vc, s_hs, s_vs, s_vo, s_pt, s_fs};
  assign obs_f = {f_hc, f_vc, f_hs, f_vs, f_vo, f_pt, f_fs};

  function automatic obs_t mk(input int h, input int v, input bit hs, input bit vs,
                              input bit vo, input bit pt, input bit fs);
    obs_t o;
    o.hcount = 10'(h);
    o.vcount = 10'(v);
    o.hsync = hs; o.vsync = vs; o.video_on = vo; o.pix_tick = pt; o.frame_start = fs;
    return o;
  endfunction

  // Raster position is simply elapsed clks / clks-per-pixel, folded into
  // line and frame lengths; strobes fall on pixel boundaries.
  function automatic obs_t model(input int clks, input int div,
                                 input int ha, input int hfp, input int hs, input int hbp,
                                 input int va, input int vfp, input int vs, input int vbp,
                                 input bit pol);
    int ht, vt, p, h, v;
    bit pt;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    p  = clks / div;
    h  = p % ht;
    v  = (p / ht) % vt;
    pt = (clks > 0) && (clks % div == 0);
    return mk(h, v,
              (h >= ha + hfp && h < ha + hfp + hs) ? pol : ~pol,
              (v >= va + vfp && v < va + vfp + vs) ? pol : ~pol,
              (h < ha) && (v < va),
              pt,
              pt && (p % (ht * vt) == 0));
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @n=%0d: got h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b",
               name, n, act.hcount, act.vcount, act.hsync, act.vsync, act.video_on,
               act.pix_tick, act.frame_start, exp.hcount, exp.vcount, exp.hsync,
               exp.vsync, exp.video_on, exp.pix_tick, exp.frame_start);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @n=%0d: got %0d, want %0d", name, n, act, exp);
    end
  endtask

  // Continuous comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dflt",  obs_d, model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      check("model_small", obs_s, model(n, 2, 8, 2, 3, 3, 6, 2, 2, 2, 1'b0));
      check("model_fast",  obs_f, model(n, 1, 8, 2, 3, 3, 6, 2, 2, 2, 1'b1));
    end
  end

  // Waits for a frame_start on the small (sel=0) or fast (sel=1) instance.
  task automatic wait_fs(input int sel, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if ((sel == 0 && s_fs) || (sel == 1 && f_fs)) begin
        ok = 1'b1;
        t  = n;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int   t0, t1, cnt, cnt2;
    bit   ok;

    // Default 640x480 instance, hsync active-low (1 = idle).
    vecs[0]  = '{0,    mk(0,   0, 1, 1, 1, 0, 0)};
    vecs[1]  = '{1,    mk(0,   0, 1, 1, 1, 0, 0)};
    vecs[2]  = '{2,    mk(1,   0, 1, 1, 1, 1, 0)};
    vecs[3]  = '{3,    mk(1,   0, 1, 1, 1, 0, 0)};
    vecs[4]  = '{1278, mk(639, 0, 1, 1, 1, 1, 0)};
    vecs[5]  = '{1280, mk(640, 0, 1, 1, 0, 1, 0)};
    vecs[6]  = '{1311, mk(655, 0, 1, 1, 0, 0, 0)};
    vecs[7]  = '{1312, mk(656, 0, 0, 1, 0, 1, 0)};
    vecs[8]  = '{1503, mk(751, 0, 0, 1, 0, 0, 0)};
    vecs[9]  = '{1504, mk(752, 0, 1, 1, 0, 1, 0)};
    vecs[10] = '{1599, mk(799, 0, 1, 1, 0, 0, 0)};
    vecs[11] = '{1600, mk(0,   1, 1, 1, 1, 1, 0)};
    vecs[12] = '{1601, mk(0,   1, 1, 1, 1, 0, 0)};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      while (n < vecs[i].n) @(negedge clk);
      check($sformatf("vec%0d", i), obs_d, vecs[i].exp);
      if (i == 0) reset = 1'b0;
    end

    // One full line of the default raster: hsync low 96 px, visible 640 px.
    cnt = 0; cnt2 = 0;
    repeat (1600) begin
      @(negedge clk);
      cnt  += (d_hs == 1'b0) ? 1 : 0;
      cnt2 += (d_vo == 1'b1) ? 1 : 0;
    end
    check_int("dflt_hsync_clks", cnt, 192);
    check_int("dflt_video_clks", cnt2, 1280);

    // Frame period and vertical sync width on the small raster.
    wait_fs(0, t0, ok);
    check_int("small_fs_seen0", int'(ok), 1);
    wait_fs(0, t1, ok);
    check_int("small_fs_seen1", int'(ok), 1);
    check_int("small_frame_period", t1 - t0, 384);
    cnt = (s_vs == 1'b0) ? 1 : 0;
    cnt2 = s_fs ? 1 : 0;
    repeat (383) begin
      @(negedge clk);
      cnt  += (s_vs == 1'b0) ? 1 : 0;
      cnt2 += s_fs ? 1 : 0;
    end
    check_int("small_vsync_clks", cnt, 64);
    check_int("small_fs_per_frame", cnt2, 1);

    // Same on the CLK_DIV=1, active-high raster.
    wait_fs(1, t0, ok);
    check_int("fast_fs_seen0", int'(ok), 1);
    wait_fs(1, t1, ok);
    check_int("fast_fs_seen1", int'(ok), 1);
    check_int("fast_frame_period", t1 - t0, 192);
    cnt = f_vs ? 1 : 0; cnt2 = f_hs ? 1 : 0;
    t0 = f_pt ? 1 : 0;
    repeat (191) begin
      @(negedge clk);
      cnt  += f_vs ? 1 : 0;
      cnt2 += f_hs ? 1 : 0;
      t0   += f_pt ? 1 : 0;
    end
    check_int("fast_vsync_clks", cnt, 32);
    check_int("fast_hsync_clks", cnt2, 36);
    check_int("fast_pix_tick_clks", t0, 192);

    // Mid-frame reset on the small raster at (10,4).
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = (s_hc == 10'd10) && (s_vc == 10'd4);
    end
    check_int("small_reach_10_4", int'(ok), 1);
    reset = 1'b1;
    @(negedge clk);
    check("small_midreset", obs_s, mk(0, 0, 1, 1, 1, 0, 0));
    check("fast_midreset",  obs_f, mk(0, 0, 0, 0, 1, 0, 0));
    reset = 1'b0;
    @(negedge clk);
    check("small_after_rst1", obs_s, mk(0, 0, 1, 1, 1, 0, 0));
    @(negedge clk);
    check("small_after_rst2", obs_s, mk(1, 0, 1, 1, 1, 1, 0));
    cnt = 0;
    repeat (381) begin
      @(negedge clk);
      cnt += s_fs ? 1 : 0;
    end
    check_int("small_no_fs_first_frame", cnt, 0);
    @(negedge clk);
    check_int("small_fs_at_384", int'(s_fs), 1);

    // Randomised run lengths and reset pulses, checked by the model.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(600, 50)) @(negedge clk);
      reset = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      reset = 1'b0;
    end
    repeat (400) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
